// File: rtl/aes_pkg.sv
// Shared AES types, key-size derivation, Rcon table and the byte/round primitives
// (S-box, inverse S-box, ShiftRows/SubBytes, MixColumns) used by the iterative core.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

  localparam logic [79:0] RCON_TABLE = 80'h01020408102040801b36;

  function automatic int unsigned nk_of(input int unsigned key_bits);
    return key_bits / 32;
  endfunction

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int k = 1; k <= 10; k++)
      if (idx == 4'(k)) r = RCON_TABLE[8*(10-k) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] v;
    v = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(v);
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of a block is state[row n%4][col n/4]; byte 0 sits in the MSBs
  function automatic logic [7:0] get_byte(input block_t b, input int n);
    return b[127-8*n -: 8];
  endfunction

  function automatic block_t sub_shift(input block_t s, input logic inv);
    block_t o;
    int     src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 4*((c + 4 - r) % 4) + r : 4*((c + r) % 4) + r;
        o[127-8*(4*c+r) -: 8] = inv ? inv_sbox(get_byte(s, src)) : sbox(get_byte(s, src));
      end
    end
    return o;
  endfunction

  function automatic block_t mix_cols(input block_t s, input logic inv);
    block_t     o;
    logic [7:0] k [4];
    logic [7:0] acc;
    o = '0;
    if (inv) begin
      k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
    end else begin
      k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gf_mul(k[(i - j + 4) % 4], get_byte(s, 4*c + i));
        o[127-8*(4*c+j) -: 8] = acc;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_word_gen.sv
// Combinational key-schedule step: produces w[i] from w[i-1] and w[i-NK].
module aes_key_word_gen
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  word_t      w_prev,
  input  word_t      w_nk,
  input  logic [5:0] idx,
  output word_t      w_new
);

  logic [5:0] idx_mod;
  logic [3:0] rc_idx;
  word_t      sub;

  always_comb begin
    idx_mod = 6'(idx % 6'(NK));
    rc_idx  = 4'(idx / 6'(NK));
    sub     = sub_word((idx_mod == 6'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    if (idx_mod == 6'd0)
      w_new = w_nk ^ sub ^ {rcon(rc_idx), 24'h000000};
    else if (NK == 8 && idx_mod == 6'd4)
      w_new = w_nk ^ sub;
    else
      w_new = w_nk ^ w_prev;
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encrypt/decrypt core: word-serial key expansion into a round-key
// bank, then one round per clock with a single start/out_valid handshake.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] key_in,
  input  logic                key_load,
  output logic                key_ready,
  input  logic                start,
  input  logic                dec,
  input  logic [127:0]        data_in,
  output logic                busy,
  output logic                out_valid,
  output logic [127:0]        data_out
);

  localparam int unsigned NK     = nk_of(KEY_BITS);
  localparam int unsigned NR     = nr_of(KEY_BITS);
  localparam int unsigned NWORDS = 4 * (NR + 1);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end

  state_t     state, state_d;
  logic [5:0] wcnt, wcnt_d;
  logic [3:0] rcnt, rcnt_d;
  logic       dec_q, dec_d;
  block_t     blk, blk_d, t_c;
  logic       exp_done, exp_done_d;
  logic       key_ready_d, busy_d, out_valid_d;
  block_t     data_out_d;
  logic       key_ld_c, exp_we_c;
  logic [3:0] rk_idx_c;
  logic [5:0] rk_base_c;
  block_t     rk_c;
  word_t      w_prev_c, w_nk_c, w_new_c;
  word_t      bank [NWORDS];

  assign w_prev_c = bank[wcnt - 6'd1];
  assign w_nk_c   = bank[wcnt - 6'(NK)];

  aes_key_word_gen #(.NK(NK)) u_key_word_gen (
    .w_prev (w_prev_c),
    .w_nk   (w_nk_c),
    .idx    (wcnt),
    .w_new  (w_new_c)
  );

  // Round-key read index: initial whitening key at start, then per-round key
  always_comb begin
    rk_idx_c = rcnt;
    if (state == IDLE)
      rk_idx_c = dec ? 4'(NR) : 4'd0;
    else if (dec_q)
      rk_idx_c = 4'(NR) - rcnt;
  end

  assign rk_base_c = {rk_idx_c, 2'b00};
  assign rk_c = {bank[rk_base_c], bank[rk_base_c + 6'd1],
                 bank[rk_base_c + 6'd2], bank[rk_base_c + 6'd3]};

  // Round-key bank: not reset, only meaningful once key_ready is set
  always_ff @(posedge clock) begin
    if (key_ld_c) begin
      for (int k = 0; k < NK; k++)
        bank[k] <= key_in[KEY_BITS-1-32*k -: 32];
    end else if (exp_we_c) begin
      bank[wcnt] <= w_new_c;
    end
  end

  always_comb begin
    state_d     = state;
    wcnt_d      = wcnt;
    rcnt_d      = rcnt;
    dec_d       = dec_q;
    blk_d       = blk;
    t_c         = '0;
    exp_done_d  = 1'b0;
    key_ready_d = key_ready | exp_done;
    out_valid_d = 1'b0;
    data_out_d  = data_out;
    key_ld_c    = 1'b0;
    exp_we_c    = 1'b0;
    case (state)
      IDLE: begin
        if (key_load) begin
          key_ld_c    = 1'b1;
          wcnt_d      = 6'(NK);
          key_ready_d = 1'b0;
          state_d     = EXPAND;
        end else if (start && key_ready) begin
          blk_d   = data_in ^ rk_c;
          dec_d   = dec;
          rcnt_d  = 4'd1;
          state_d = ROUND;
        end
      end
      EXPAND: begin
        if (key_load) begin
          key_ld_c = 1'b1;
          wcnt_d   = 6'(NK);
        end else begin
          exp_we_c = 1'b1;
          wcnt_d   = wcnt + 6'd1;
          if (wcnt == 6'(NWORDS - 1)) begin
            exp_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      ROUND: begin
        if (!dec_q) begin
          t_c = sub_shift(blk, 1'b0);
          if (rcnt != 4'(NR)) t_c = mix_cols(t_c, 1'b0);
          blk_d = t_c ^ rk_c;
        end else begin
          t_c = sub_shift(blk, 1'b1) ^ rk_c;
          if (rcnt != 4'(NR)) t_c = mix_cols(t_c, 1'b1);
          blk_d = t_c;
        end
        if (rcnt == 4'(NR)) state_d = DONE;
        else                rcnt_d  = rcnt + 4'd1;
      end
      DONE: begin
        data_out_d  = blk;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      dec_q     <= 1'b0;
      blk       <= '0;
      exp_done  <= 1'b0;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      rcnt      <= rcnt_d;
      dec_q     <= dec_d;
      blk       <= blk_d;
      exp_done  <= exp_done_d;
      key_ready <= key_ready_d;
      busy      <= busy_d;
      out_valid <= out_valid_d;
      data_out  <= data_out_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: one instance per key size, FIPS-197 vectors
// in a table plus hand-written handshake, restart and reset sequences.
module tb_aes_iter_core;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clock = 1'b0;
  logic         reset;
  logic [2:0]   key_load, start, dec;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [127:0] din [3];
  wire  [2:0]   key_ready, busy, out_valid;
  wire  [127:0] dout0, dout1, dout2;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  aes_iter_core #(.KEY_BITS(128)) u_aes128 (
    .clock(clock), .reset(reset), .key_in(key128), .key_load(key_load[0]),
    .key_ready(key_ready[0]), .start(start[0]), .dec(dec[0]), .data_in(din[0]),
    .busy(busy[0]), .out_valid(out_valid[0]), .data_out(dout0));

  aes_iter_core #(.KEY_BITS(192)) u_aes192 (
    .clock(clock), .reset(reset), .key_in(key192), .key_load(key_load[1]),
    .key_ready(key_ready[1]), .start(start[1]), .dec(dec[1]), .data_in(din[1]),
    .busy(busy[1]), .out_valid(out_valid[1]), .data_out(dout1));

  aes_iter_core #(.KEY_BITS(256)) u_aes256 (
    .clock(clock), .reset(reset), .key_in(key256), .key_load(key_load[2]),
    .key_ready(key_ready[2]), .start(start[2]), .dec(dec[2]), .data_in(din[2]),
    .busy(busy[2]), .out_valid(out_valid[2]), .data_out(dout2));

  typedef struct {
    string        name;
    int           d;
    logic         dv;
    logic [127:0] data;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [127:0] dout_of(input int d);
    case (d)
      0:       return dout0;
      1:       return dout1;
      default: return dout2;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_key(input int d, input logic real_key);
    case (d)
      0:       key128 = real_key ? K128 : ~K128;
      1:       key192 = real_key ? K192 : ~K192;
      default: key256 = real_key ? K256 : ~K256;
    endcase
  endtask

  task automatic load_key(input int d, input logic real_key, input logic with_start);
    set_key(d, real_key);
    key_load[d] = 1'b1;
    start[d]    = with_start;
    din[d]      = PT;
    @(posedge clock); #1;
    key_load[d] = 1'b0;
    start[d]    = 1'b0;
    set_key(d, ~real_key);
  endtask

  task automatic wait_key(input int d, output int lat, output int ov_seen);
    lat     = -1;
    ov_seen = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clock); #1;
      if (out_valid[d]) ov_seen++;
      if (key_ready[d]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic apply_start(input int d, input logic dv, input logic [127:0] data);
    start[d] = 1'b1;
    dec[d]   = dv;
    din[d]   = data;
    @(posedge clock); #1;
    start[d] = 1'b0;
    dec[d]   = ~dv;
    din[d]   = ~data;
  endtask

  task automatic wait_ov(input int d, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (out_valid[d]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_ov(input int d, input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clock); #1;
      if (out_valid[d]) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, cnt;
    logic dv;

    vecs[0] = '{"enc128", 0, 1'b0, PT,    CT128, 11};
    vecs[1] = '{"dec128", 0, 1'b1, CT128, PT,    11};
    vecs[2] = '{"enc192", 1, 1'b0, PT,    CT192, 13};
    vecs[3] = '{"dec192", 1, 1'b1, CT192, PT,    13};
    vecs[4] = '{"enc256", 2, 1'b0, PT,    CT256, 15};
    vecs[5] = '{"dec256", 2, 1'b1, CT256, PT,    15};

    reset    = 1'b0;
    key_load = '0;
    start    = '0;
    dec      = '0;
    key128   = '0;
    key192   = '0;
    key256   = '0;
    for (int d = 0; d < 3; d++) din[d] = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;

    check("reset_flags", 128'({key_ready, busy, out_valid}), 128'h0);
    for (int d = 0; d < 3; d++) check($sformatf("reset_dout%0d", d), dout_of(d), 128'h0);

    // start with no key loaded
    apply_start(0, 1'b0, PT);
    count_ov(0, 20, cnt);
    check("nokey_start_ov", 128'(cnt), 128'd0);
    check("nokey_start_dout", dout_of(0), 128'h0);
    check("nokey_start_busy", 128'(busy[0]), 128'd0);

    load_key(0, 1'b1, 1'b0);
    wait_key(0, lat, cnt);
    check("keyrdy_lat128", 128'(lat), 128'd41);

    // second key_load mid-expansion restarts from the new key
    load_key(1, 1'b0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("busy_expand192", 128'(busy[1]), 128'd1);
    load_key(1, 1'b1, 1'b0);
    wait_key(1, lat, cnt);
    check("keyrdy_lat192_restart", 128'(lat), 128'd47);

    load_key(2, 1'b1, 1'b0);
    wait_key(2, lat, cnt);
    check("keyrdy_lat256", 128'(lat), 128'd53);

    for (int v = 0; v < 6; v++) begin
      apply_start(vecs[v].d, vecs[v].dv, vecs[v].data);
      wait_ov(vecs[v].d, lat);
      check({vecs[v].name, "_data"}, dout_of(vecs[v].d), vecs[v].exp);
      check({vecs[v].name, "_lat"}, 128'(lat), 128'(vecs[v].lat));
    end

    // back-to-back alternating blocks, each started right after out_valid
    for (int k = 0; k < 3; k++) begin
      dv = (k % 2) == 1;
      apply_start(2, dv, dv ? CT256 : PT);
      wait_ov(2, lat);
      check($sformatf("b2b%0d_data", k), dout2, dv ? PT : CT256);
      check($sformatf("b2b%0d_lat", k), 128'(lat), 128'd15);
    end

    // start while busy is dropped, not queued
    apply_start(0, 1'b0, PT);
    repeat (2) @(posedge clock);
    #1;
    apply_start(0, 1'b1, 128'hdeadbeef);
    wait_ov(0, lat);
    check("busy_start_lat", 128'(lat), 128'd8);
    check("busy_start_data", dout0, CT128);
    count_ov(0, 20, cnt);
    check("busy_start_no_extra_ov", 128'(cnt), 128'd0);

    // key_load during ROUND is ignored and the key survives
    apply_start(0, 1'b1, CT128);
    repeat (2) @(posedge clock);
    #1;
    set_key(0, 1'b0);
    key_load[0] = 1'b1;
    @(posedge clock); #1;
    key_load[0] = 1'b0;
    wait_ov(0, lat);
    check("round_keyload_lat", 128'(lat), 128'd8);
    check("round_keyload_data", dout0, PT);
    check("round_keyload_keyrdy", 128'(key_ready[0]), 128'd1);
    apply_start(0, 1'b0, PT);
    wait_ov(0, lat);
    check("key_persist_data", dout0, CT128);

    // key_load and start together: expansion only
    load_key(0, 1'b1, 1'b1);
    wait_key(0, lat, cnt);
    check("ld_start_keyrdy_lat", 128'(lat), 128'd41);
    check("ld_start_no_ov", 128'(cnt), 128'd0);
    check("ld_start_dout_held", dout0, CT128);

    // reset in the middle of a block
    apply_start(2, 1'b0, PT);
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("midreset_flags", 128'({key_ready, busy, out_valid}), 128'h0);
    check("midreset_dout2", dout2, 128'h0);
    check("midreset_dout0", dout0, 128'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    apply_start(2, 1'b0, PT);
    count_ov(2, 20, cnt);
    check("postreset_start_ov", 128'(cnt), 128'd0);
    check("postreset_dout", dout2, 128'h0);
    check("postreset_keyrdy", 128'(key_ready[2]), 128'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
